// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: routes I/D requests to word-interleaved SRAM banks, resolves same-bank conflicts and returns read data one cycle later.
module mem_bank_arbiter #(
    parameter int NUM_BANKS = 2,
    parameter int DATA_W    = 32,
    parameter int BANK_AW   = 14,
    parameter int RR_EN     = 1,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req_valid,
    output logic                           i_req_ready,
    input  logic [31:0]                    i_req_addr,
    output logic                           i_resp_valid,
    output logic [DATA_W-1:0]              i_resp_data,
    input  logic                           d_req_valid,
    output logic                           d_req_ready,
    input  logic [31:0]                    d_req_addr,
    input  logic [DATA_W/8-1:0]            d_req_wstrb,
    input  logic [DATA_W-1:0]              d_req_wdata,
    output logic                           d_resp_valid,
    output logic [DATA_W-1:0]              d_resp_data,
    output logic [NUM_BANKS-1:0]           bank_ceb,
    output logic [NUM_BANKS-1:0]           bank_web,
    output logic [NUM_BANKS*DATA_W-1:0]    bank_bweb,
    output logic [NUM_BANKS*BANK_AW-1:0]   bank_a,
    output logic [NUM_BANKS*DATA_W-1:0]    bank_di,
    input  logic [NUM_BANKS*DATA_W-1:0]    bank_do,
    output logic [CNT_W-1:0]               conflict_cnt
);
    localparam int SB = $clog2(NUM_BANKS);
    localparam int BW = SB > 0 ? SB : 1;
    logic [BW-1:0] i_bank, d_bank, i_bank_q, d_bank_q;
    logic [BANK_AW-1:0] i_row, d_row;
    logic [NUM_BANKS-1:0] i_sel, d_sel;
    logic [DATA_W-1:0] wmask;
    logic d_wr, conflict, d_win, i_acc, d_acc, prio_d, i_pend, d_pend;
    logic unused_addr;
    assign unused_addr = ^{i_req_addr, d_req_addr};
    assign i_bank = NUM_BANKS > 1 ? BW'(i_req_addr >> 2) : '0;
    assign d_bank = NUM_BANKS > 1 ? BW'(d_req_addr >> 2) : '0;
    assign i_row = BANK_AW'(i_req_addr >> (2 + SB));
    assign d_row = BANK_AW'(d_req_addr >> (2 + SB));
    assign d_wr = |d_req_wstrb;
    assign conflict = i_req_valid && d_req_valid && i_bank == d_bank;
    assign d_win = RR_EN == 0 || prio_d;
    // ready is suppressed during reset so nothing is accepted while state is being cleared
    assign i_req_ready = !rst && !(conflict && d_win);
    assign d_req_ready = !rst && !(conflict && !d_win);
    assign i_acc = i_req_valid && i_req_ready;
    assign d_acc = d_req_valid && d_req_ready;
    assign i_sel = i_acc ? NUM_BANKS'(1) << i_bank : '0;
    assign d_sel = d_acc ? NUM_BANKS'(1) << d_bank : '0;
    assign i_resp_valid = i_pend;
    assign d_resp_valid = d_pend;
    assign i_resp_data = i_pend ? bank_do[i_bank_q*DATA_W +: DATA_W] : '0;
    assign d_resp_data = d_pend ? bank_do[d_bank_q*DATA_W +: DATA_W] : '0;
    always_comb begin
        wmask = '0;
        for (int k = 0; k < DATA_W/8; k++) wmask[k*8 +: 8] = {8{d_req_wstrb[k]}};
    end
    always_comb begin
        bank_ceb = '1;
        bank_web = '1;
        bank_bweb = '1;
        bank_a = '0;
        bank_di = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_ceb[b] = !(i_sel[b] || d_sel[b]);
            bank_web[b] = !(d_sel[b] && d_wr);
            bank_bweb[b*DATA_W +: DATA_W] = d_sel[b] && d_wr ? ~wmask : '1;
            bank_a[b*BANK_AW +: BANK_AW] = d_sel[b] ? d_row : i_sel[b] ? i_row : '0;
            bank_di[b*DATA_W +: DATA_W] = i_sel[b] || d_sel[b] ? d_req_wdata : '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_d <= 1'b1;
            conflict_cnt <= '0;
            i_pend <= 1'b0;
            d_pend <= 1'b0;
            i_bank_q <= '0;
            d_bank_q <= '0;
        end else begin
            i_pend <= i_acc;
            d_pend <= d_acc && !d_wr;
            if (i_acc) i_bank_q <= i_bank;
            if (d_acc) d_bank_q <= d_bank;
            if (conflict) begin
                prio_d <= RR_EN != 0 ? !d_win : 1'b1;
                if (!(&conflict_cnt)) conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed checks of banking, arbitration, responses and reset; a second instance covers fixed priority and a 2-bit counter.
module tb_mem_bank_arbiter;
    logic clk = 1'b0, rst;
    logic i_req_valid, d_req_valid;
    logic [31:0] i_req_addr, d_req_addr, d_req_wdata;
    logic [3:0] d_req_wstrb;
    logic i_req_ready, d_req_ready, i_resp_valid, d_resp_valid;
    logic [31:0] i_resp_data, d_resp_data;
    logic [1:0] bank_ceb, bank_web;
    logic [63:0] bank_bweb, bank_di, bank_do;
    logic [27:0] bank_a;
    logic [15:0] conflict_cnt;
    logic f_i_req_ready, f_d_req_ready, f_i_resp_valid, f_d_resp_valid;
    logic [31:0] f_i_resp_data, f_d_resp_data;
    logic [1:0] f_bank_ceb, f_bank_web, f_conflict_cnt;
    logic [63:0] f_bank_bweb, f_bank_di;
    logic [27:0] f_bank_a;
    logic [31:0] mem [2][16];
    logic [31:0] rdo [2];
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    mem_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .bank_ceb(bank_ceb), .bank_web(bank_web), .bank_bweb(bank_bweb),
        .bank_a(bank_a), .bank_di(bank_di), .bank_do(bank_do),
        .conflict_cnt(conflict_cnt)
    );
    mem_bank_arbiter #(.RR_EN(0), .CNT_W(2)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(f_i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(f_i_resp_valid), .i_resp_data(f_i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(f_d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_resp_valid(f_d_resp_valid), .d_resp_data(f_d_resp_data),
        .bank_ceb(f_bank_ceb), .bank_web(f_bank_web), .bank_bweb(f_bank_bweb),
        .bank_a(f_bank_a), .bank_di(f_bank_di), .bank_do(64'd0),
        .conflict_cnt(f_conflict_cnt)
    );
    // bank model: word (b+1)<<28 | row, with bank0 row2 preset for the byte-merge case
    assign bank_do = {rdo[1], rdo[0]};
    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 16; r++) mem[b][r] <= (32'(b + 1) << 28) | 32'(r);
            mem[0][2] <= 32'h11223344;
        end else begin
            for (int b = 0; b < 2; b++)
                if (!bank_ceb[b]) begin
                    if (!bank_web[b])
                        mem[b][bank_a[b*14 +: 4]] <= (mem[b][bank_a[b*14 +: 4]] & bank_bweb[b*32 +: 32])
                                                    | (bank_di[b*32 +: 32] & ~bank_bweb[b*32 +: 32]);
                    else
                        rdo[b] <= mem[b][bank_a[b*14 +: 4]];
                end
        end
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h8;
        d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
        repeat (2) tick();
        check("rst_i_ready", i_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_ceb", bank_ceb, 2'b11);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_i_resp_valid", i_resp_valid, 0);
        check("rst_d_resp_data", d_resp_data, 0);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        rst = 1'b0;
        tick();
        // different banks in the same cycle, then back-to-back fetches
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h4;
        #2;
        check("t1_i_ready", i_req_ready, 1);
        check("t1_d_ready", d_req_ready, 1);
        check("t1_ceb", bank_ceb, 2'b00);
        tick();
        i_req_addr = 32'h8; d_req_valid = 1'b0;
        check("t1_i_resp_valid", i_resp_valid, 1);
        check("t1_i_resp_data", i_resp_data, 32'h10000000);
        check("t1_d_resp_valid", d_resp_valid, 1);
        check("t1_d_resp_data", d_resp_data, 32'h20000000);
        #2;
        check("t1_i_ready_pipelined", i_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        check("t1_i_resp2_valid", i_resp_valid, 1);
        check("t1_i_resp2_data", i_resp_data, 32'h10000001);
        check("t1_d_resp_one_cycle", d_resp_valid, 0);
        tick();
        check("t1_i_resp_one_cycle", i_resp_valid, 0);
        // same-bank conflict held five cycles: round-robin D,I,D,I,D vs fixed D
        i_req_valid = 1'b1; i_req_addr = 32'h8;
        d_req_valid = 1'b1; d_req_addr = 32'h8;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("rr_d_ready", d_req_ready, k % 2 == 0);
            check("rr_i_ready", i_req_ready, k % 2 != 0);
            check("fp_d_ready", f_d_req_ready, 1);
            check("fp_i_ready", f_i_req_ready, 0);
            if (k == 0) check("rr_bank_a", bank_a[13:0], 14'd1);
            tick();
            if (k == 4) begin
                i_req_valid = 1'b0; d_req_valid = 1'b0;
            end
            check("rr_cnt", conflict_cnt, 16'(k + 1));
            check("fp_cnt_sat", f_conflict_cnt, k < 3 ? 2'(k + 1) : 2'd3);
            check("rr_d_resp_valid", d_resp_valid, k % 2 == 0);
            check("rr_i_resp_valid", i_resp_valid, k % 2 != 0);
            check("rr_resp_data", k % 2 == 0 ? d_resp_data : i_resp_data, 32'h10000001);
        end
        tick();
        // partial write then read-back of the merged word
        d_req_valid = 1'b1; d_req_addr = 32'h10;
        d_req_wstrb = 4'b0101; d_req_wdata = 32'hAABBCCDD;
        #2;
        check("wr_web", bank_web, 2'b10);
        check("wr_bweb", bank_bweb[31:0], 32'hFF00FF00);
        check("wr_bank1_bweb", bank_bweb[63:32], 32'hFFFFFFFF);
        check("wr_a", bank_a[13:0], 14'd2);
        tick();
        check("wr_no_resp", d_resp_valid, 0);
        d_req_wstrb = 4'b0000;
        tick();
        d_req_valid = 1'b0;
        check("rd_after_wr_valid", d_resp_valid, 1);
        check("rd_after_wr_data", d_resp_data, 32'h11BB33DD);
        tick();
        // reset lands in the response cycle; priority afterwards is D again
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        tick();
        i_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst6_i_resp_valid", i_resp_valid, 0);
        check("rst6_i_resp_data", i_resp_data, 0);
        check("rst6_cnt", conflict_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        i_req_valid = 1'b1; i_req_addr = 32'h8;
        d_req_valid = 1'b1; d_req_addr = 32'h8;
        #2;
        check("rst6_prio_d_ready", d_req_ready, 1);
        check("rst6_prio_i_ready", i_req_ready, 0);
        tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        check("rst6_cnt_after", conflict_cnt, 1);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
